// File: rtl/branch_resolver.sv
// branch_resolver
// Execute-stage partner of the branch predictor. Predictions issued at fetch
// are held in a small in-order queue. When execute resolves the oldest branch,
// the queued prediction is compared with the real outcome. The block then
// trains the predictor and, on a wrong prediction, flushes and redirects fetch.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   predValid/predReady, predPC, predTaken, predTarget
//                      prediction push from fetch (predReady = count < DEPTH)
//   exValid, exPC, exTaken, exTarget
//                      resolution of the oldest in-flight branch
//   branchResolved     one-cycle training pulse, with actualTaken/resolvedPC
//   predictCorrect     held result of the last comparison
//   mispredict         one-cycle flush pulse, with redirectPC
//   orphanError        sticky: resolution without a matching queued prediction
//   resolveCount, mispredictCount
//                      saturating performance counters (CNTW bits)
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            predValid,
  output logic            predReady,
  input  logic [31:0]     predPC,
  input  logic            predTaken,
  input  logic [31:0]     predTarget,
  input  logic            exValid,
  input  logic [31:0]     exPC,
  input  logic            exTaken,
  input  logic [31:0]     exTarget,
  output logic            branchResolved,
  output logic            actualTaken,
  output logic [31:0]     resolvedPC,
  output logic            predictCorrect,
  output logic            mispredict,
  output logic [31:0]     redirectPC,
  output logic            orphanError,
  output logic [CNTW-1:0] resolveCount,
  output logic [CNTW-1:0] mispredictCount
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Queue storage (data only, never reset; count_q qualifies its contents)
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  entry_t head;
  logic   empty, pc_match, correct, flush, push, pop;

  assign empty     = (count_q == '0);
  assign predReady = (count_q < DEPTH_C);

  // An empty queue resolves against a default not-taken entry at exPC, so
  // only the direction/target decide correctness; the orphan flag records it.
  always_comb begin
    head = mem_q[head_q];
    if (empty) begin
      head = '{pc: exPC, taken: 1'b0, target: 32'h0};
    end
  end

  assign pc_match = (head.pc == exPC);
  assign correct  = pc_match && (head.taken == exTaken) &&
                    (!exTaken || (head.target == exTarget));
  assign flush    = exValid && !correct;
  // A push racing a flush is on the wrong path and is dropped.
  assign push     = predValid && predReady && !flush;
  assign pop      = exValid && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{pc: predPC, taken: predTaken, target: predTarget};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Resolution stage: outputs registered one cycle after exValid
  logic            br_q, at_q, ok_q, mis_q, orph_q;
  logic [31:0]     rpc_q, rdr_q;
  logic [CNTW-1:0] rc_q, mc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_q   <= 1'b0;
      at_q   <= 1'b0;
      ok_q   <= 1'b0;
      mis_q  <= 1'b0;
      orph_q <= 1'b0;
      rpc_q  <= '0;
      rdr_q  <= '0;
      rc_q   <= '0;
      mc_q   <= '0;
    end else begin
      br_q  <= exValid;
      mis_q <= flush;
      if (exValid) begin
        at_q  <= exTaken;
        rpc_q <= exPC;
        ok_q  <= correct;
        rdr_q <= exTaken ? exTarget : exPC + 32'd4;
        rc_q  <= sat_inc(rc_q);
        if (!correct)           mc_q   <= sat_inc(mc_q);
        if (empty || !pc_match) orph_q <= 1'b1;
      end
    end
  end

  assign branchResolved  = br_q;
  assign actualTaken     = at_q;
  assign resolvedPC      = rpc_q;
  assign predictCorrect  = ok_q;
  assign mispredict      = mis_q;
  assign redirectPC      = rdr_q;
  assign orphanError     = orph_q;
  assign resolveCount    = rc_q;
  assign mispredictCount = mc_q;

endmodule
